// File: rtl/rad4_pkg.sv
// rad4_pkg -- shared definitions for the radix-4 restoring divider.
//   DIGIT_W : quotient bits retired per CALC cycle (radix 4 -> 2 bits).
//   state_t : divider FSM state encoding.
// Optional feature macro: RAD4_DIVIDER_SIGNED_EN adds the FIX state used for
// two's-complement sign correction.
package rad4_pkg;

  localparam int unsigned DIGIT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
`ifdef RAD4_DIVIDER_SIGNED_EN
    S_FIX  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rad4_digit_sel.sv
// rad4_digit_sel -- combinational radix-4 quotient digit selection.
// Ports:
//   i_pp  [wI+1:0]      shifted partial remainder P' = {P, next 2 dividend MSBs}
//   i_d   [wI-1:0]      divisor magnitude D
//   o_k   [DIGIT_W-1:0] largest k in 0..3 with k*D <= P'
//   o_rem [wI-1:0]      P' - k*D
module rad4_digit_sel
  import rad4_pkg::*;
#(
  parameter int unsigned wI = 32
) (
  input  logic [wI+1:0]      i_pp,
  input  logic [wI-1:0]      i_d,
  output logic [DIGIT_W-1:0] o_k,
  output logic [wI-1:0]      o_rem
);

  logic [wI+1:0] w_d1;
  logic [wI+1:0] w_d2;
  logic [wI+1:0] w_d3;

  assign w_d1 = {2'b00, i_d};
  assign w_d2 = {1'b0, i_d, 1'b0};
  assign w_d3 = w_d1 + w_d2;

  // The true difference is always below D, so it fits in wI bits and the
  // subtraction can be done on the low wI bits only (modulo arithmetic).
  always_comb begin
    o_k   = '0;
    o_rem = i_pp[wI-1:0];
    if (i_pp >= w_d3) begin
      o_k   = DIGIT_W'(3);
      o_rem = i_pp[wI-1:0] - w_d3[wI-1:0];
    end else if (i_pp >= w_d2) begin
      o_k   = DIGIT_W'(2);
      o_rem = i_pp[wI-1:0] - w_d2[wI-1:0];
    end else if (i_pp >= w_d1) begin
      o_k   = DIGIT_W'(1);
      o_rem = i_pp[wI-1:0] - w_d1[wI-1:0];
    end
  end

endmodule

// File: rtl/rad4_divider.sv
// rad4_divider -- iterative restoring radix-4 divider, 2 quotient bits/cycle.
// Ports:
//   iClk, iRst_n        clock, asynchronous active-low reset
//   iStart              operation request, sampled only while idle
//   iX, iY  [wI-1:0]    dividend, divisor (captured on accepted iStart)
//   oBusy               high whenever the FSM is not idle
//   oDone               one-cycle pulse; oQ/oR/oDivZero valid from this cycle
//   oQ, oR  [wI-1:0]    quotient, remainder (held until the next oDone)
//   oDivZero            divisor was zero (oQ = all ones, oR = iX)
// Parameter wI must be even and >= 4.
// Optional feature macro: RAD4_DIVIDER_SIGNED_EN -- two's-complement operands,
// quotient/remainder truncated toward zero, corrected in an extra FIX cycle.
module rad4_divider
  import rad4_pkg::*;
#(
  parameter int unsigned wI = 32
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iStart,
  input  logic [wI-1:0] iX,
  input  logic [wI-1:0] iY,
  output logic          oBusy,
  output logic          oDone,
  output logic [wI-1:0] oQ,
  output logic [wI-1:0] oR,
  output logic          oDivZero
);

  localparam int unsigned CW = $clog2(wI / 2);
  localparam logic [CW-1:0] CNT_INIT = CW'(wI / 2 - 1);

  state_t              r_state;
  logic [wI-1:0]       r_x;      // dividend shift register, refills with quotient digits
  logic [wI-1:0]       r_d;
  logic [wI-1:0]       r_p;      // partial remainder
  logic [CW-1:0]       r_cnt;
  logic                r_dz;
  logic                r_done;
  logic [wI-1:0]       r_q_out;
  logic [wI-1:0]       r_r_out;
  logic                r_dz_out;

  logic [wI+1:0]       w_pp;
  logic [DIGIT_W-1:0]  w_k;
  logic [wI-1:0]       w_rem;
  logic [wI-1:0]       w_xmag;
  logic [wI-1:0]       w_ymag;

`ifdef RAD4_DIVIDER_SIGNED_EN
  logic                r_negq;
  logic                r_negr;

  // Most-negative dividend maps to magnitude 2^(wI-1), which is still correct
  // when read as unsigned; MIN / -1 therefore wraps back to MIN on negation.
  assign w_xmag = iX[wI-1] ? -iX : iX;
  assign w_ymag = iY[wI-1] ? -iY : iY;
`else
  assign w_xmag = iX;
  assign w_ymag = iY;
`endif

  assign w_pp = {r_p, r_x[wI-1 -: DIGIT_W]};

  rad4_digit_sel #(.wI(wI)) u_digit_sel (
    .i_pp  (w_pp),
    .i_d   (r_d),
    .o_k   (w_k),
    .o_rem (w_rem)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_d      <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_q_out  <= '0;
      r_r_out  <= '0;
      r_dz_out <= 1'b0;
`ifdef RAD4_DIVIDER_SIGNED_EN
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_p   <= '0;
            r_cnt <= CNT_INIT;
            r_d   <= w_ymag;
`ifdef RAD4_DIVIDER_SIGNED_EN
            r_negq <= iX[wI-1] ^ iY[wI-1];
            r_negr <= iX[wI-1];
`endif
            if (iY == '0) begin
              // Raw dividend is kept so it can be returned as the remainder.
              r_x     <= iX;
              r_dz    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_x     <= w_xmag;
              r_dz    <= 1'b0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_x <= {r_x[wI-DIGIT_W-1:0], w_k};
          r_p <= w_rem;
          if (r_cnt == '0) begin
`ifdef RAD4_DIVIDER_SIGNED_EN
            r_state <= S_FIX;
`else
            r_state <= S_DONE;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`ifdef RAD4_DIVIDER_SIGNED_EN
        S_FIX: begin
          if (r_negq) r_x <= -r_x;
          if (r_negr) r_p <= -r_p;
          r_state <= S_DONE;
        end
`endif
        S_DONE: begin
          r_done   <= 1'b1;
          r_q_out  <= r_dz ? '1 : r_x;
          r_r_out  <= r_dz ? r_x : r_p;
          r_dz_out <= r_dz;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oBusy    = (r_state != S_IDLE);
  assign oDone    = r_done;
  assign oQ       = r_q_out;
  assign oR       = r_r_out;
  assign oDivZero = r_dz_out;

endmodule

// File: tb/tb_rad4_divider.sv
// tb_rad4_divider -- scoreboard bench for rad4_divider (wI = 32).
// Honours RAD4_DIVIDER_SIGNED_EN for the reference model and latency.
module tb_rad4_divider;

  localparam int unsigned WI = 32;

  logic          iClk;
  logic          iRst_n;
  logic          iStart;
  logic [WI-1:0] iX;
  logic [WI-1:0] iY;
  logic          oBusy;
  logic          oDone;
  logic [WI-1:0] oQ;
  logic [WI-1:0] oR;
  logic          oDivZero;

  rad4_divider #(.wI(WI)) dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iStart   (iStart),
    .iX       (iX),
    .iY       (iY),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oQ       (oQ),
    .oR       (oR),
    .oDivZero (oDivZero)
  );

  typedef struct {
    logic [WI-1:0] q;
    logic [WI-1:0] r;
    logic          dz;
    int            lat;
    int            cap;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;
  logic [WI-1:0] last_q = '0;
  logic [WI-1:0] last_r = '0;

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WI-1:0] x, input logic [WI-1:0] y);
    exp_t e;
    logic signed [WI-1:0] xs;
    logic signed [WI-1:0] ys;
    xs = x;
    ys = y;
    e.cap = 0;
    if (y == '0) begin
      e.q = '1; e.r = x; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.dz = 1'b0;
`ifdef RAD4_DIVIDER_SIGNED_EN
      e.lat = WI / 2 + 2;
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        e.q = x; e.r = '0;
      end else begin
        e.q = xs / ys;
        e.r = xs % ys;
      end
`else
      e.lat = WI / 2 + 1;
      e.q = x / y;
      e.r = x % y;
      if (xs == ys) e.lat = WI / 2 + 1;
`endif
    end
    return e;
  endfunction

  // Scoreboard consumer: every oDone pops and checks one expectation.
  always @(negedge iClk) begin
    if (iRst_n && oDone) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(oDone), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q",       64'(oQ),       64'(e.q));
        check("r",       64'(oR),       64'(e.r));
        check("divzero", 64'(oDivZero), 64'(e.dz));
        check("latency", 64'(cyc - e.cap), 64'(e.lat));
        last_q = e.q;
        last_r = e.r;
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after capture.
  task automatic start_op(input logic [WI-1:0] x, input logic [WI-1:0] y);
    exp_t e;
    e = model(x, y);
    e.cap = cyc + 1;
    sb.push_back(e);
    iX = x;
    iY = y;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    iX = $urandom;
    iY = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (oBusy && n < 100) begin
      @(negedge iClk);
      n++;
    end
    if (oBusy) check("timeout_idle", 64'(oBusy), 64'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!oDone && n < 100) begin
      @(negedge iClk);
      n++;
    end
    if (!oDone) check("timeout_done", 64'(oDone), 64'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge iClk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout_drain", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge iClk);
  endtask

  initial begin
    iRst_n = 1'b0;
    iStart = 1'b0;
    iX = '0;
    iY = '0;
    repeat (2) @(negedge iClk);
    check("rst_busy",    64'(oBusy),    64'd0);
    check("rst_done",    64'(oDone),    64'd0);
    check("rst_q",       64'(oQ),       64'd0);
    check("rst_r",       64'(oR),       64'd0);
    check("rst_divzero", 64'(oDivZero), 64'd0);

    // Start accepted on the very first edge after release.
    iRst_n = 1'b1;
    start_op(32'd100, 32'd7);
    check("busy_after_start", 64'(oBusy), 64'd1);
    wait_drain();

    // Back-to-back: second request issued during the first oDone cycle.
    start_op(32'hFFFF_FFFF, 32'd1);
    wait_done();
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("b2b_accept", 64'(oBusy), 64'd1);
    wait_drain();

    start_op(32'd1234, 32'd0);
    wait_drain();
    check("hold_q", 64'(oQ), 64'(last_q));
    check("hold_r", 64'(oR), 64'(last_r));

    start_op(32'hFFFF_FFF9, 32'd2);
    wait_drain();
    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_drain();

    // Request during CALC cycle 5 must be ignored.
    start_op(32'd50_000, 32'd123);
    repeat (4) @(negedge iClk);
    iX = 32'd9;
    iY = 32'd3;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    check("ignore_busy", 64'(oBusy), 64'd1);
    wait_drain();
    repeat (20) @(negedge iClk);
    check("ignore_no_extra", 64'(sb.size()), 64'd0);
    check("hold_q_idle", 64'(oQ), 64'(last_q));

    // Abort mid-CALC with reset.
    start_op(32'd777_777, 32'd11);
    repeat (7) @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    check("abort_busy",    64'(oBusy),    64'd0);
    check("abort_done",    64'(oDone),    64'd0);
    check("abort_q",       64'(oQ),       64'd0);
    check("abort_r",       64'(oR),       64'd0);
    check("abort_divzero", 64'(oDivZero), 64'd0);
    void'(sb.pop_front());
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    start_op(32'd1_000_003, 32'd97);
    wait_drain();

    for (int i = 0; i < 6; i++) begin
      logic [WI-1:0] x;
      logic [WI-1:0] y;
      x = $urandom;
      y = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      if (y == '0) y = 32'd5;
      start_op(x, y);
      wait_drain();
    end

    wait_idle();
    check("final_queue", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rad4_divider.md
RAD4_DIVIDER -- requirements
Module: rad4_divider

Interface
REQ-001 SHALL have parameter wI, default 32, operand width; must be even and at least 4.
REQ-002 SHALL have port iClk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port iRst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port iStart, input, 1, operation request, sampled only in IDLE.
REQ-005 SHALL have port iX, input, wI, dividend.
REQ-006 SHALL have port iY, input, wI, divisor.
REQ-007 SHALL have port oBusy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port oDone, output, 1, one-cycle pulse marking valid results.
REQ-009 SHALL have port oQ, output, wI, quotient.
REQ-010 SHALL have port oR, output, wI, remainder.
REQ-011 SHALL have port oDivZero, output, 1, divide-by-zero flag, valid with oDone.

Function
REQ-012 SHALL implement a restoring radix-4 divider retiring 2 quotient bits per CALC cycle.
REQ-013 SHALL use FSM states IDLE, CALC, FIX, DONE.
REQ-014 IDLE with iStart=1 SHALL capture iX and iY, clear the partial remainder and load iteration counter = wI/2-1.
REQ-015 From IDLE, the FSM SHALL go to CALC, or to DONE when iY==0.
REQ-016 Each CALC cycle SHALL form P' = {P, next 2 dividend MSBs}.
REQ-017 Each CALC cycle SHALL compare P' against D, 2D and 3D at wI+2 bits.
REQ-018 Each CALC cycle SHALL select digit k as the largest multiple kD with kD <= P', store P'-kD and shift k into the quotient LSBs.
REQ-019 CALC SHALL last exactly wI/2 cycles, then go to FIX if signed mode is compiled in, else to DONE.
REQ-020 DONE SHALL assert oDone for exactly one cycle, then return to IDLE.
REQ-021 Latency from the iStart capture edge to oDone high SHALL be wI/2+1 cycles unsigned and wI/2+2 cycles signed (17 or 18 for wI=32).
REQ-022 Divide-by-zero SHALL complete in 1 cycle with oQ=all ones, oR=iX and oDivZero=1.
REQ-023 oDivZero SHALL be 0 on every other completion.
REQ-024 iStart SHALL be ignored while oBusy=1; operands change freely after capture.
REQ-025 oQ, oR and oDivZero SHALL hold their last results until the next oDone.
REQ-026 iStart SHALL be accepted in the cycle immediately after oDone (back-to-back operation).

Reset
REQ-027 Reset assertion SHALL force IDLE and oBusy=0, oDone=0, oQ=0, oR=0, oDivZero=0, including mid-operation (the operation is aborted, with no oDone).
REQ-028 Reset release SHALL need no further initialisation; iStart is accepted on the first clock edge after release.

Configuration
REQ-029 With macro RAD4_DIVIDER_SIGNED_EN defined, operands SHALL be two's complement: magnitudes are taken at capture.
REQ-030 With RAD4_DIVIDER_SIGNED_EN defined, FIX SHALL negate the quotient if the operand signs differ and negate the remainder if the dividend is negative (truncation toward zero).
REQ-031 With RAD4_DIVIDER_SIGNED_EN defined, the most-negative value divided by -1 SHALL return oQ=most-negative and oR=0.
REQ-032 Without RAD4_DIVIDER_SIGNED_EN, operands SHALL be unsigned and the FIX state and its logic SHALL be absent.

Structure
REQ-033 Shared package rad4_pkg SHALL hold the FSM state enum and the digit-width constant (2).
REQ-034 Digit selection SHALL be the combinational sub-module rad4_digit_sel: inputs P' and D; outputs digit k and P'-kD.
REQ-035 Sequencing, registers and the counter SHALL reside in rad4_divider.

Verification
REQ-036 Scenario: iX=100, iY=7, unsigned -> oQ=14, oR=2, oDivZero=0, oDone 17 cycles after capture.
REQ-037 Scenario: iX=0xFFFFFFFF, iY=1 and then iY=0xFFFFFFFF, back-to-back -> oQ=0xFFFFFFFF, oR=0; then oQ=1, oR=0; the second iStart is accepted the cycle after the first oDone.
REQ-038 Scenario: iX=1234, iY=0 -> oQ=0xFFFFFFFF, oR=1234, oDivZero=1, oDone 1 cycle after capture.
REQ-039 Scenario: RAD4_DIVIDER_SIGNED_EN defined, iX=-7, iY=2 -> oQ=-3, oR=-1, oDone after 18 cycles; iX=0x80000000, iY=-1 -> oQ=0x80000000, oR=0.
REQ-040 Scenario: iStart pulsed at CALC cycle 5 with different operands -> ignored; the original result is unchanged.
REQ-041 Scenario: iRst_n asserted low at CALC cycle 8 -> all outputs 0, no oDone; a new operation after release completes correctly.
